commit_trace_buffer: RTL and testbench

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/commit_trace_buffer.sv | 129 ++++++++++++
 tb/tb_commit_trace_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_buffer
// Brief    : Retired-instruction trace FIFO with commit counter, overflow and
//            control-flow discontinuity detection.
// Revision : 1.0 - initial release
// ============================================================================
module commit_trace_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit,
    input  logic [31:0]              commit_pc,
    input  logic [31:0]              commit_pre_pc,
    input  logic                     clear,
    input  logic                     trace_ready,
    output logic                     trace_valid,
    output logic [31:0]              trace_pc,
    output logic [31:0]              trace_next_pc,
    output logic [31:0]              trace_seq,
    output logic [31:0]              commit_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     flow_err,
    output logic [31:0]              flow_err_pc
);

    localparam int              AW     = $clog2(DEPTH);
    localparam int              LW     = AW + 1;
    localparam logic [LW-1:0]   C_FULL = LW'(DEPTH);

    logic [31:0]   r_mem_pc  [DEPTH];
    logic [31:0]   r_mem_npc [DEPTH];
    logic [31:0]   r_mem_seq [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [31:0]   r_cnt;
    logic          r_overflow;
    logic          r_flow_err;
    logic [31:0]   r_flow_err_pc;
    logic [31:0]   r_exp_pc;
    logic          r_exp_valid;

    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign w_full = (r_level == C_FULL);
    assign w_pop  = (r_level != '0) && trace_ready;
    // A full FIFO still accepts a commit when the head leaves in the same cycle.
    assign w_push = commit && (!w_full || w_pop);

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]  <= commit_pc;
            r_mem_npc[r_wr_ptr] <= commit_pre_pc;
            r_mem_seq[r_wr_ptr] <= r_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
            if (commit) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    // Sticky status; clear wins over any flag set in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow    <= 1'b0;
            r_flow_err    <= 1'b0;
            r_flow_err_pc <= '0;
            r_exp_pc      <= '0;
            r_exp_valid   <= 1'b0;
        end else if (clear) begin
            r_overflow    <= 1'b0;
            r_flow_err    <= 1'b0;
            r_flow_err_pc <= '0;
            r_exp_valid   <= commit;
            if (commit) begin
                r_exp_pc <= commit_pre_pc;
            end
        end else if (commit) begin
            r_exp_pc    <= commit_pre_pc;
            r_exp_valid <= 1'b1;
            if (w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (r_exp_valid && (commit_pc != r_exp_pc) && !r_flow_err) begin
                r_flow_err    <= 1'b1;
                r_flow_err_pc <= commit_pc;
            end
        end
    end

    assign trace_valid   = (r_level != '0);
    assign trace_pc      = r_mem_pc[r_rd_ptr];
    assign trace_next_pc = r_mem_npc[r_rd_ptr];
    assign trace_seq     = r_mem_seq[r_rd_ptr];
    assign commit_cnt    = r_cnt;
    assign fifo_level    = r_level;
    assign overflow      = r_overflow;
    assign flow_err      = r_flow_err;
    assign flow_err_pc   = r_flow_err_pc;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_trace_buffer
// Brief    : Scoreboard bench for commit_trace_buffer with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_trace_buffer;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        commit;
    logic [31:0] commit_pc;
    logic [31:0] commit_pre_pc;
    logic        clear;
    logic        trace_ready;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_next_pc;
    logic [31:0] trace_seq;
    logic [31:0] commit_cnt;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        flow_err;
    logic [31:0] flow_err_pc;

    int errors = 0;
    int checks = 0;

    logic [95:0] sb[$];
    int          m_level = 0;
    logic [31:0] m_cnt   = 0;

    commit_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .commit        (commit),
        .commit_pc     (commit_pc),
        .commit_pre_pc (commit_pre_pc),
        .clear         (clear),
        .trace_ready   (trace_ready),
        .trace_valid   (trace_valid),
        .trace_pc      (trace_pc),
        .trace_next_pc (trace_next_pc),
        .trace_seq     (trace_seq),
        .commit_cnt    (commit_cnt),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .flow_err      (flow_err),
        .flow_err_pc   (flow_err_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted head entry must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && trace_valid && trace_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_entry", trace_seq, 32'hFFFF_FFFF);
            end else begin
                logic [95:0] e;
                e = sb.pop_front();
                chk("sb_pc",   trace_pc,      e[95:64]);
                chk("sb_npc",  trace_next_pc, e[63:32]);
                chk("sb_seq",  trace_seq,     e[31:0]);
            end
        end
    end

    // Drive one cycle of stimulus and record what the FIFO should accept.
    task automatic cyc(input logic c, input logic [31:0] pc, input logic [31:0] pre,
                       input logic rdy, input logic clr);
        logic pop;
        logic push;
        commit        = c;
        commit_pc     = pc;
        commit_pre_pc = pre;
        trace_ready   = rdy;
        clear         = clr;
        pop  = (m_level != 0) && rdy;
        push = c && ((m_level < DEPTH) || pop);
        if (push) sb.push_back({pc, pre, m_cnt});
        if (c) m_cnt = m_cnt + 32'd1;
        m_level = m_level + (push ? 1 : 0) - (pop ? 1 : 0);
        @(posedge clk);
        #1;
        commit = 1'b0;
        clear  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; commit = 1'b0; commit_pc = '0; commit_pre_pc = '0;
        clear = 1'b0; trace_ready = 1'b0;
        #3;
        chk("rst_valid",    {31'd0, trace_valid}, 32'd0);
        chk("rst_level",    {28'd0, fifo_level},  32'd0);
        chk("rst_cnt",      commit_cnt,           32'd0);
        chk("rst_overflow", {31'd0, overflow},    32'd0);
        chk("rst_flow_err", {31'd0, flow_err},    32'd0);
        chk("rst_err_pc",   flow_err_pc,          32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // In-order stream, consumer always ready.
        cyc(1, 32'h0, 32'h4, 1, 0);
        chk("latency_valid", {31'd0, trace_valid}, 32'd1);
        cyc(1, 32'h4, 32'h8, 1, 0);
        cyc(1, 32'h8, 32'hC, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);
        chk("seq_cnt",      commit_cnt,           32'd3);
        chk("seq_flow_err", {31'd0, flow_err},    32'd0);
        chk("seq_drained",  {28'd0, fifo_level},  32'd0);

        // Discontinuity capture and hold of the first faulting PC.
        cyc(0, 0, 0, 1, 1);
        cyc(1, 32'h0,  32'h4,  1, 0);
        cyc(1, 32'h10, 32'h14, 1, 0);
        chk("disc_flag", {31'd0, flow_err}, 32'd1);
        chk("disc_pc",   flow_err_pc,       32'h10);
        cyc(1, 32'h40, 32'h44, 1, 0);
        chk("disc_hold_pc", flow_err_pc, 32'h10);

        // Clear together with a commit: push still happens, checking restarts.
        cyc(1, 32'h20, 32'h24, 1, 1);
        chk("clr_flow_err", {31'd0, flow_err}, 32'd0);
        chk("clr_err_pc",   flow_err_pc,       32'd0);
        cyc(1, 32'h24, 32'h28, 1, 0);
        chk("clr_next_ok",  {31'd0, flow_err}, 32'd0);
        chk("clr_cnt",      commit_cnt,        32'd8);
        repeat (2) cyc(0, 0, 0, 1, 0);

        // Fill with consumer stalled; the ninth commit is dropped.
        for (int i = 0; i < 9; i++)
            cyc(1, 32'h28 + 32'(4 * i), 32'h2C + 32'(4 * i), 0, 0);
        chk("full_level",    {28'd0, fifo_level}, 32'd8);
        chk("full_overflow", {31'd0, overflow},   32'd1);
        chk("full_cnt",      commit_cnt,          32'd17);
        chk("stall_pc",      trace_pc,            32'h28);
        chk("stall_npc",     trace_next_pc,       32'h2C);
        chk("stall_seq",     trace_seq,           32'd8);

        // Full FIFO with simultaneous pop accepts the commit without overflow.
        cyc(0, 0, 0, 0, 1);
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        cyc(1, 32'h4C, 32'h50, 1, 0);
        chk("pp_level",    {28'd0, fifo_level}, 32'd8);
        chk("pp_overflow", {31'd0, overflow},   32'd0);
        repeat (9) cyc(0, 0, 0, 1, 0);
        chk("pp_drained",  {28'd0, fifo_level}, 32'd0);

        // Asynchronous reset with entries buffered.
        for (int i = 0; i < 5; i++)
            cyc(1, 32'h80 + 32'(4 * i), 32'h84 + 32'(4 * i), 0, 0);
        chk("pre_rst_level", {28'd0, fifo_level}, 32'd5);
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, trace_valid}, 32'd0);
        chk("arst_level", {28'd0, fifo_level},  32'd0);
        chk("arst_cnt",   commit_cnt,           32'd0);
        sb.delete();
        m_level = 0;
        m_cnt   = 0;
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        cyc(1, 32'h100, 32'h104, 1, 0);
        repeat (2) cyc(0, 0, 0, 1, 0);
        chk("post_rst_cnt", commit_cnt, 32'd1);
        chk("sb_empty",     32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
